// File: rtl/hazard_if.sv
// hazard_if: decode register requests, writeback retire and scoreboard status
interface hazard_if #(parameter int ADDR_WIDTH = 5);
  logic                  id_valid;
  logic                  read_enable1;
  logic [ADDR_WIDTH-1:0] read_addr1;
  logic                  read_enable2;
  logic [ADDR_WIDTH-1:0] read_addr2;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic                  wb_enable;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic                  stall;
  logic                  issue;
  logic                  busy_any;
  logic [31:0]           stall_cycles;
  logic                  underflow_err;
  modport master (
    output id_valid, read_enable1, read_addr1, read_enable2, read_addr2,
           write_enable, write_addr, wb_enable, wb_addr,
    input  stall, issue, busy_any, stall_cycles, underflow_err
  );
  modport slave (
    input  id_valid, read_enable1, read_addr1, read_enable2, read_addr2,
           write_enable, write_addr, wb_enable, wb_addr,
    output stall, issue, busy_any, stall_cycles, underflow_err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write counters gating decode issue
module hazard_scoreboard #(
  parameter int REG_COUNT  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 2
) (
  input logic     clock,
  input logic     reset,
  hazard_if.slave sb
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  logic [CNT_WIDTH-1:0] cnt_q [REG_COUNT];
  logic [CNT_WIDTH-1:0] cnt_d [REG_COUNT];
  logic [REG_COUNT-1:0] inc, dec;
  logic                 busy_any_q, busy_any_d;
  logic                 underflow_err_q, underflow_err_d;
  logic [31:0]          stall_cycles_q, stall_cycles_d;
  logic                 raw1, raw2, waw, stall_c, issue_c, retire_zero;
  // hazards look only at registered counters, so a retire never bypasses into the same cycle
  always_comb begin
    raw1 = sb.read_enable1 && sb.read_addr1 != '0 && cnt_q[sb.read_addr1] != '0;
    raw2 = sb.read_enable2 && sb.read_addr2 != '0 && cnt_q[sb.read_addr2] != '0;
    waw = sb.write_enable && sb.write_addr != '0 && cnt_q[sb.write_addr] == CNT_MAX;
    stall_c = !reset && sb.id_valid && (raw1 || raw2 || waw);
    issue_c = !reset && sb.id_valid && !(raw1 || raw2 || waw);
    retire_zero = sb.wb_enable && sb.wb_addr != '0 && cnt_q[sb.wb_addr] == '0;
    busy_any_d = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) begin
      inc[i] = i != 0 && issue_c && sb.write_enable && sb.write_addr == ADDR_WIDTH'(i);
      dec[i] = i != 0 && sb.wb_enable && sb.wb_addr == ADDR_WIDTH'(i) && cnt_q[i] != '0;
      cnt_d[i] = (inc[i] && !dec[i]) ? cnt_q[i] + CNT_WIDTH'(1) :
                 (dec[i] && !inc[i]) ? cnt_q[i] - CNT_WIDTH'(1) : cnt_q[i];
      busy_any_d = busy_any_d || cnt_d[i] != '0;
    end
    underflow_err_d = underflow_err_q || retire_zero;
    stall_cycles_d = (stall_c && stall_cycles_q != '1) ? stall_cycles_q + 32'd1 : stall_cycles_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) cnt_q[i] <= '0;
      busy_any_q      <= 1'b0;
      underflow_err_q <= 1'b0;
      stall_cycles_q  <= '0;
    end else begin
      cnt_q           <= cnt_d;
      busy_any_q      <= busy_any_d;
      underflow_err_q <= underflow_err_d;
      stall_cycles_q  <= stall_cycles_d;
    end
  end
  assign sb.stall         = stall_c;
  assign sb.issue         = issue_c;
  assign sb.busy_any      = busy_any_q;
  assign sb.underflow_err = underflow_err_q;
  assign sb.stall_cycles  = stall_cycles_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table, reset-drop sequence and randomized model check
module tb_hazard_scoreboard;
  typedef struct {
    logic        rst, idv, re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic        we;
    logic [4:0]  wa;
    logic        wbe;
    logic [4:0]  wba;
    logic        st, is, busy;
    logic [31:0] sc;
    logic        uf;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   m_cnt [32];
  logic m_busy, m_uf;
  logic [31:0] m_sc;
  logic m_stall, m_issue;
  vec_t tbl [31];
  hazard_if #(.ADDR_WIDTH(5)) bus ();
  hazard_scoreboard #(.REG_COUNT(32), .ADDR_WIDTH(5), .CNT_WIDTH(2)) dut (
    .clock(clk), .reset(rst), .sb(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(input logic r, i, e1, input int a1, input logic e2, input int a2,
                             input logic w, input int wa, input logic b, input int ba,
                             input logic st, is, busy, input int sc, input logic uf);
    vec_t t;
    t.rst = r; t.idv = i; t.re1 = e1; t.ra1 = 5'(a1); t.re2 = e2; t.ra2 = 5'(a2);
    t.we = w; t.wa = 5'(wa); t.wbe = b; t.wba = 5'(ba);
    t.st = st; t.is = is; t.busy = busy; t.sc = 32'(sc); t.uf = uf;
    return t;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic pend(input logic en, input logic [4:0] a);
    return en && a != 0 && m_cnt[a] != 0;
  endfunction
  // mode 0: drive only, 1: compare against table row, 2: compare against reference model
  task automatic cycle(input vec_t t, input int mode, input string tag);
    @(negedge clk);
    rst = t.rst;
    bus.id_valid = t.idv; bus.read_enable1 = t.re1; bus.read_addr1 = t.ra1;
    bus.read_enable2 = t.re2; bus.read_addr2 = t.ra2;
    bus.write_enable = t.we; bus.write_addr = t.wa;
    bus.wb_enable = t.wbe; bus.wb_addr = t.wba;
    #1;
    m_stall = !t.rst && t.idv && (pend(t.re1, t.ra1) || pend(t.re2, t.ra2) ||
              (t.we && t.wa != 0 && m_cnt[t.wa] == 3));
    m_issue = !t.rst && t.idv && !m_stall;
    if (mode == 1) begin
      chk({tag, " stall"}, 32'(bus.stall), 32'(t.st));
      chk({tag, " issue"}, 32'(bus.issue), 32'(t.is));
      chk({tag, " busy_any"}, 32'(bus.busy_any), 32'(t.busy));
      chk({tag, " stall_cycles"}, bus.stall_cycles, t.sc);
      chk({tag, " underflow_err"}, 32'(bus.underflow_err), 32'(t.uf));
    end else if (mode == 2) begin
      chk({tag, " stall"}, 32'(bus.stall), 32'(m_stall));
      chk({tag, " issue"}, 32'(bus.issue), 32'(m_issue));
      chk({tag, " busy_any"}, 32'(bus.busy_any), 32'(m_busy));
      chk({tag, " stall_cycles"}, bus.stall_cycles, m_sc);
      chk({tag, " underflow_err"}, 32'(bus.underflow_err), 32'(m_uf));
    end
    @(posedge clk);
    if (t.rst) begin
      foreach (m_cnt[k]) m_cnt[k] = 0;
      m_uf = 0; m_sc = 0; m_busy = 0;
    end else begin
      if (t.wbe && t.wba != 0) begin
        if (m_cnt[t.wba] != 0) m_cnt[t.wba]--;
        else m_uf = 1;
      end
      if (m_issue && t.we && t.wa != 0) m_cnt[t.wa]++;
      if (m_stall && m_sc != 32'hFFFF_FFFF) m_sc++;
      m_busy = 0;
      foreach (m_cnt[k]) if (m_cnt[k] != 0) m_busy = 1;
    end
  endtask
  initial begin
    vec_t t;
    foreach (m_cnt[k]) m_cnt[k] = 0;
    m_busy = 0; m_uf = 0; m_sc = 0;
    //            rst i e1 a1 e2 a2 we wa wbe wba  st is bz sc uf
    tbl[0]  = v(1, 1, 1, 5, 1, 6, 1, 7, 1, 3,   0, 0, 0, 0, 0);
    tbl[1]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    tbl[2]  = v(0, 1, 0, 0, 0, 0, 1, 5, 0, 0,   0, 1, 0, 0, 0);
    tbl[3]  = v(0, 1, 1, 5, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0);
    tbl[4]  = v(0, 1, 1, 5, 0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 0);
    tbl[5]  = v(0, 1, 1, 5, 0, 0, 0, 0, 1, 5,   1, 0, 1, 2, 0);
    tbl[6]  = v(0, 1, 1, 5, 0, 0, 0, 0, 0, 0,   0, 1, 0, 3, 0);
    tbl[7]  = v(0, 1, 0, 0, 0, 0, 1, 7, 0, 0,   0, 1, 0, 3, 0);
    tbl[8]  = v(0, 1, 0, 0, 0, 0, 1, 7, 0, 0,   0, 1, 1, 3, 0);
    tbl[9]  = v(0, 1, 0, 0, 0, 0, 1, 7, 0, 0,   0, 1, 1, 3, 0);
    tbl[10] = v(0, 1, 0, 0, 0, 0, 1, 7, 0, 0,   1, 0, 1, 3, 0);
    tbl[11] = v(0, 1, 0, 0, 0, 0, 1, 7, 1, 7,   1, 0, 1, 4, 0);
    tbl[12] = v(0, 1, 0, 0, 0, 0, 1, 7, 0, 0,   0, 1, 1, 5, 0);
    tbl[13] = v(0, 1, 0, 0, 0, 0, 1, 7, 0, 0,   1, 0, 1, 5, 0);
    tbl[14] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 7,   0, 0, 1, 6, 0);
    tbl[15] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 7,   0, 0, 1, 6, 0);
    tbl[16] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 7,   0, 0, 1, 6, 0);
    tbl[17] = v(0, 1, 0, 0, 0, 0, 1, 9, 0, 0,   0, 1, 0, 6, 0);
    tbl[18] = v(0, 1, 0, 0, 0, 0, 1, 9, 1, 9,   0, 1, 1, 6, 0);
    tbl[19] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 6, 0);
    tbl[20] = v(0, 1, 1, 9, 0, 0, 0, 0, 0, 0,   1, 0, 1, 6, 0);
    tbl[21] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 9,   0, 0, 1, 7, 0);
    tbl[22] = v(0, 1, 1, 0, 1, 0, 1, 0, 0, 0,   0, 1, 0, 7, 0);
    tbl[23] = v(0, 1, 1, 0, 1, 0, 1, 0, 0, 0,   0, 1, 0, 7, 0);
    tbl[24] = v(0, 1, 1, 0, 1, 0, 1, 0, 1, 0,   0, 1, 0, 7, 0);
    tbl[25] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 7, 0);
    tbl[26] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 12,  0, 0, 0, 7, 0);
    tbl[27] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 7, 1);
    tbl[28] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 7, 1);
    tbl[29] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 7, 1);
    tbl[30] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    cycle(tbl[29], 0, "init");
    cycle(tbl[29], 0, "init");
    foreach (tbl[i]) cycle(tbl[i], 1, $sformatf("row%0d", i));
    // a reset drops the pending write, so its later retire is an underflow
    cycle(v(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0), 2, "flush_wr");
    cycle(v(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2, "flush_raw");
    cycle(v(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2, "flush_rst");
    cycle(v(0, 1, 1, 3, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0), 2, "flush_wb");
    cycle(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2, "flush_uf");
    chk("flush_uf_direct", 32'(bus.underflow_err), 32'd1);
    for (int n = 0; n < 3000; n++) begin
      t = v($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7),
            1'($urandom), $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7),
            $urandom_range(0, 2) == 0, $urandom_range(0, 7), 0, 0, 0, 0, 0);
      for (int k = 0; k < 4 && m_cnt[t.wba] == 0; k++) t.wba = 5'($urandom_range(0, 7));
      cycle(t, 2, $sformatf("rand%0d", n));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
